// File: rtl/pico16a_pkg.sv
// Shared definitions for the PICO16a CPU: instruction layout, opcodes and FSM states.
package pico16a_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int NUM_HEX  = 8;

    // Instruction field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 5;
    localparam int IMM8_W = 8;
    localparam int IMM11_W = 11;

    // One-hot CPU states; the encoding is shown directly on LEDG[3:0]
    localparam logic [3:0] ST_FETCH  = 4'b0001;
    localparam logic [3:0] ST_DECODE = 4'b0010;
    localparam logic [3:0] ST_EXEC   = 4'b0100;
    localparam logic [3:0] ST_MEM    = 4'b1000;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_MV   = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_ADD  = 5'd5,
        OP_SUB  = 5'd6,
        OP_SL   = 5'd7,
        OP_SR   = 5'd8,
        OP_LDLI = 5'd9,
        OP_LDHI = 5'd10,
        OP_ADDI = 5'd11,
        OP_LD   = 5'd12,
        OP_ST   = 5'd13,
        OP_BEZ  = 5'd14,
        OP_BNEZ = 5'd15,
        OP_BMI  = 5'd16,
        OP_BPL  = 5'd17,
        OP_JMP  = 5'd18,
        OP_HALT = 5'd19
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [2:0] rd;
        logic [7:0] low;
    } instr_t;

    function automatic logic [DATA_W-1:0] sext8(input logic [IMM8_W-1:0] v);
        return {{(DATA_W-IMM8_W){v[IMM8_W-1]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [IMM11_W-1:0] v);
        return {{(DATA_W-IMM11_W){v[IMM11_W-1]}}, v};
    endfunction

endpackage

// File: rtl/pico16a_rmem.sv
// Unified program/data RAM: synchronous write, registered read, wraps on the low AW address bits.
module pico16a_rmem #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    // mem_data is the target for hex preloading of programs
    logic [DW-1:0] mem_data [2**AW];
    logic [DW-1:0] rdata_q;

    always @(posedge clk) begin
        if (we) begin
            mem_data[addr] <= wdata;
        end
        rdata_q <= mem_data[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/seg7_dec.sv
// Hex nibble to active-low seven-segment glyph, bit 0 = segment a .. bit 6 = segment g.
module seg7_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'h00;
        case (nibble)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign seg_n = ~seg_on;

endmodule

// File: rtl/pico16a_system.sv
// PICO16a board top: multi-cycle 16-bit CPU, unified RAM, and switch/LED/7-segment I/O.
module pico16a_system
    import pico16a_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic        EXT_CLOCK,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [8:0]  LEDG,
    output logic [17:0] LEDR,
    output logic        LCD_ON,
    output logic        LCD_BLON,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_RS,
    output logic [7:0]  LCD_DATA
);

    logic clk;
    logic rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

    logic [3:0]        state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              run;
    logic [2:0]        rd_idx;
    logic [2:0]        rs_idx;
    logic [7:0]        imm8;
    logic [10:0]       imm11;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] branch_target;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    assign run           = SW[17] && !halted_q;
    assign rd_idx        = ir_q.rd;
    assign rs_idx        = ir_q.low[RS_HI:RS_LO];
    assign imm8          = ir_q.low;
    assign imm11         = {ir_q.rd, ir_q.low};
    assign rd_val        = regs_q[rd_idx];
    assign rs_val        = regs_q[rs_idx];
    // pc_q already holds PC+1 by EXEC, so it is the branch base
    assign branch_target = pc_q + sext8(imm8);

    // Data accesses use rs during EXEC (load address) and MEM (store address)
    assign mem_addr = ((state_q == ST_EXEC) || (state_q == ST_MEM))
                      ? rs_val[MEM_AW-1:0] : pc_q[MEM_AW-1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        regs_d   = regs_q;
        mem_we   = 1'b0;
        if (run) begin
            case (state_q)
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = instr_t'(mem_rdata);
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (ir_q.opcode)
                        OP_MV:   regs_d[rd_idx] = rs_val;
                        OP_AND:  regs_d[rd_idx] = rd_val & rs_val;
                        OP_OR:   regs_d[rd_idx] = rd_val | rs_val;
                        OP_XOR:  regs_d[rd_idx] = rd_val ^ rs_val;
                        OP_ADD:  regs_d[rd_idx] = rd_val + rs_val;
                        OP_SUB:  regs_d[rd_idx] = rd_val - rs_val;
                        OP_SL:   regs_d[rd_idx] = {rd_val[DATA_W-2:0], 1'b0};
                        OP_SR:   regs_d[rd_idx] = {1'b0, rd_val[DATA_W-1:1]};
                        OP_LDLI: regs_d[rd_idx] = sext8(imm8);
                        OP_LDHI: regs_d[rd_idx] = {imm8, 8'h00};
                        OP_ADDI: regs_d[rd_idx] = rd_val + sext8(imm8);
                        OP_LD, OP_ST: state_d = ST_MEM;
                        OP_BEZ:  if (rd_val == '0) pc_d = branch_target;
                        OP_BNEZ: if (rd_val != '0) pc_d = branch_target;
                        OP_BMI:  if (rd_val[DATA_W-1]) pc_d = branch_target;
                        OP_BPL:  if (!rd_val[DATA_W-1]) pc_d = branch_target;
                        OP_JMP:  pc_d = pc_q + sext11(imm11);
                        OP_HALT: halted_d = 1'b1;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    state_d = ST_FETCH;
                    if (ir_q.opcode == OP_LD) begin
                        regs_d[rd_idx] = mem_rdata;
                    end else if (ir_q.opcode == OP_ST) begin
                        mem_we = rst_n;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    pico16a_rmem #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) rmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (rd_val),
        .rdata (mem_rdata)
    );

    // Low four digits show either a selected register or the instruction register
    logic [DATA_W-1:0] disp_word;
    logic [31:0]       hex_nibbles;
    logic [6:0]        hex_seg [NUM_HEX];

    assign disp_word   = SW[16] ? DATA_W'(ir_q) : regs_q[SW[2:0]];
    assign hex_nibbles = {pc_q, disp_word};

    generate
        for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
            seg7_dec u_seg (
                .nibble (hex_nibbles[gi*4 +: 4]),
                .seg_n  (hex_seg[gi])
            );
        end
    endgenerate

    assign HEX0 = hex_seg[0];
    assign HEX1 = hex_seg[1];
    assign HEX2 = hex_seg[2];
    assign HEX3 = hex_seg[3];
    assign HEX4 = hex_seg[4];
    assign HEX5 = hex_seg[5];
    assign HEX6 = hex_seg[6];
    assign HEX7 = hex_seg[7];

    assign LEDG     = {halted_q, 4'b0000, state_q};
    assign LEDR     = SW;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = 1'b0;
    assign LCD_RS   = 1'b0;
    assign LCD_DATA = 8'h00;

    logic unused_inputs;
    assign unused_inputs = ^{EXT_CLOCK, KEY[3:1], rs_val[DATA_W-1:MEM_AW]};

endmodule

// File: tb/tb_pico16a_system.sv
// Self-checking bench for pico16a_system against an instruction-level reference model.
module tb_pico16a_system;

    logic        clk = 1'b0;
    logic [3:0]  key;
    logic        ext_clk = 1'b0;
    logic [17:0] sw;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [8:0]  ledg;
    logic [17:0] ledr;
    logic        lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    pico16a_system #(.MEM_AW(10)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .EXT_CLOCK(ext_clk),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .HEX6     (hex6),
        .HEX7     (hex7),
        .LEDG     (ledg),
        .LEDR     (ledr),
        .LCD_ON   (lcd_on),
        .LCD_BLON (lcd_blon),
        .LCD_RW   (lcd_rw),
        .LCD_EN   (lcd_en),
        .LCD_RS   (lcd_rs),
        .LCD_DATA (lcd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] C_NOP = 5'd0,  C_MV = 5'd1,   C_AND = 5'd2,  C_OR = 5'd3;
    localparam logic [4:0] C_XOR = 5'd4,  C_ADD = 5'd5,  C_SUB = 5'd6,  C_SL = 5'd7;
    localparam logic [4:0] C_SR = 5'd8,   C_LDLI = 5'd9, C_LDHI = 5'd10, C_ADDI = 5'd11;
    localparam logic [4:0] C_LD = 5'd12,  C_ST = 5'd13,  C_BEZ = 5'd14, C_BNEZ = 5'd15;
    localparam logic [4:0] C_BMI = 5'd16, C_BPL = 5'd17, C_JMP = 5'd18, C_HALT = 5'd19;

    // Reference machine state
    logic [15:0] m_mem [1024];
    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    bit          m_halt;
    logic [15:0] prog_q [$];

    function automatic logic [15:0] enc_rr(input logic [4:0] op, input int rd, input int rs);
        return {op, 3'(rd), 3'(rs), 5'd0};
    endfunction

    function automatic logic [15:0] enc_ri(input logic [4:0] op, input int rd, input int imm);
        return {op, 3'(rd), 8'(imm)};
    endfunction

    function automatic logic [15:0] enc_j(input int off);
        return {C_JMP, 11'(off)};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] glyphs16(input logic [15:0] v);
        return {glyph(v[15:12]), glyph(v[11:8]), glyph(v[7:4]), glyph(v[3:0])};
    endfunction

    // Executes the program in m_mem one instruction at a time from the ISA rules
    task automatic model_run(output int cyc);
        logic [15:0] ins, a, b, nxt;
        logic [4:0]  op;
        int rd, rs, s8, s11;
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_pc = 16'h0;
        m_halt = 1'b0;
        cyc = 0;
        for (int n = 0; n < 4000 && !m_halt; n++) begin
            ins = m_mem[m_pc[9:0]];
            op  = ins[15:11];
            rd  = int'(ins[10:8]);
            rs  = int'(ins[7:5]);
            s8  = int'(ins[7:0]);
            if (s8 > 127) s8 -= 256;
            s11 = int'(ins[10:0]);
            if (s11 > 1023) s11 -= 2048;
            a = m_r[rd];
            b = m_r[rs];
            nxt = m_pc + 16'd1;
            m_pc = nxt;
            cyc += 3;
            case (op)
                C_MV:   m_r[rd] = b;
                C_AND:  m_r[rd] = a & b;
                C_OR:   m_r[rd] = a | b;
                C_XOR:  m_r[rd] = a ^ b;
                C_ADD:  m_r[rd] = 16'(int'(a) + int'(b));
                C_SUB:  m_r[rd] = 16'(int'(a) - int'(b));
                C_SL:   m_r[rd] = 16'(int'(a) * 2);
                C_SR:   m_r[rd] = 16'(int'(a) / 2);
                C_LDLI: m_r[rd] = 16'(s8);
                C_LDHI: m_r[rd] = {ins[7:0], 8'h00};
                C_ADDI: m_r[rd] = 16'(int'(a) + s8);
                C_LD: begin m_r[rd] = m_mem[b[9:0]]; cyc += 1; end
                C_ST: begin m_mem[b[9:0]] = a; cyc += 1; end
                C_BEZ:  if (a == 16'h0) m_pc = 16'(int'(nxt) + s8);
                C_BNEZ: if (a != 16'h0) m_pc = 16'(int'(nxt) + s8);
                C_BMI:  if (a[15]) m_pc = 16'(int'(nxt) + s8);
                C_BPL:  if (!a[15]) m_pc = 16'(int'(nxt) + s8);
                C_JMP:  m_pc = 16'(int'(nxt) + s11);
                C_HALT: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic hold_reset();
        key[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Both memories cleared, then prog_q placed from address 0 (call while in reset)
    task automatic load_program();
        for (int i = 0; i < 1024; i++) begin
            dut.rmem.mem_data[i] <= 16'h0;
            m_mem[i] = 16'h0;
        end
        for (int i = 0; i < prog_q.size(); i++) begin
            dut.rmem.mem_data[i] <= prog_q[i];
            m_mem[i] = prog_q[i];
        end
        #0;
    endtask

    task automatic poke(input int addr, input logic [15:0] val);
        dut.rmem.mem_data[addr] <= val;
        m_mem[addr] = val;
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        key[0] = 1'b1;
        cyc = 0;
        while (cyc < budget && ledg[8] !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        sw = {1'b1, 1'b0, 13'($urandom), 3'd0};
        hold_reset();
        n_checks++;
        if ({hex7, hex6, hex5, hex4} !== glyphs16(16'h0000)) begin
            n_fail++; $display("FAIL reset_pc_hex: got %h expected %h", {hex7, hex6, hex5, hex4}, glyphs16(16'h0));
        end
        n_checks++;
        if (ledg !== 9'b0_0000_0001) begin
            n_fail++; $display("FAIL reset_ledg: got %b expected %b", ledg, 9'b0_0000_0001);
        end
        n_checks++;
        if ({lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs, lcd_data} !== {5'b11000, 8'h00}) begin
            n_fail++; $display("FAIL reset_lcd: got %b expected %b",
                {lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs, lcd_data}, {5'b11000, 8'h00});
        end
        n_checks++;
        if (ledr !== sw) begin
            n_fail++; $display("FAIL ledr_mirror: got %h expected %h", ledr, sw);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dut.regs_q[i] !== 16'h0) begin
                n_fail++; $display("FAIL reset_r%0d: got %h expected 0000", i, dut.regs_q[i]);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_alu_imm();
        int cyc, mcyc;
        logic [15:0] pc_at_halt;
        prog_q = '{enc_ri(C_LDLI, 1, 8'h7F), enc_ri(C_LDHI, 2, 8'h12), enc_rr(C_ADD, 2, 1), enc_rr(C_HALT, 0, 0)};
        hold_reset();
        load_program();
        model_run(mcyc);
        run_to_halt(200, cyc);
        n_checks++;
        if (dut.regs_q[2] !== 16'h127F) begin
            n_fail++; $display("FAIL alu_r2: got %h expected 127f", dut.regs_q[2]);
        end
        n_checks++;
        if (cyc !== 12 || ledg[8] !== 1'b1) begin
            n_fail++; $display("FAIL alu_halt_cycles: got %0d halted=%b expected 12 halted=1", cyc, ledg[8]);
        end
        pc_at_halt = dut.pc_q;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (dut.pc_q !== 16'd4 || pc_at_halt !== 16'd4) begin
            n_fail++; $display("FAIL alu_pc_frozen: got %h/%h expected 0004", pc_at_halt, dut.pc_q);
        end
        $display("test_alu_imm: r2=%h cycles=%0d model_cycles=%0d", dut.regs_q[2], cyc, mcyc);
    endtask

    task automatic test_random_alu();
        logic [4:0] ops [13] = '{C_NOP, C_MV, C_AND, C_OR, C_XOR, C_ADD, C_SUB,
                                 C_SL, C_SR, C_LDLI, C_LDHI, C_ADDI, 5'h1F};
        int cyc, mcyc;
        for (int it = 0; it < 4; it++) begin
            prog_q = {};
            for (int k = 0; k < 24; k++) begin
                prog_q.push_back({ops[$urandom_range(0, 12)], 11'($urandom)});
            end
            prog_q.push_back(enc_rr(C_HALT, 0, 0));
            hold_reset();
            load_program();
            model_run(mcyc);
            run_to_halt(500, cyc);
            n_checks++;
            if (cyc !== mcyc) begin
                n_fail++; $display("FAIL rand_alu_cycles[%0d]: got %0d expected %0d", it, cyc, mcyc);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (dut.regs_q[i] !== m_r[i]) begin
                    n_fail++; $display("FAIL rand_alu_r%0d[%0d]: got %h expected %h", i, it, dut.regs_q[i], m_r[i]);
                end
            end
            $display("test_random_alu[%0d]: cycles=%0d r0=%h r7=%h", it, cyc, m_r[0], m_r[7]);
        end
    endtask

    task automatic test_load_store();
        int cyc, mcyc;
        prog_q = '{enc_ri(C_LDLI, 4, 8'h40), enc_rr(C_SL, 4, 0), enc_rr(C_LD, 3, 4),
                   enc_ri(C_ADDI, 3, 3), enc_rr(C_ST, 3, 4), enc_rr(C_HALT, 0, 0)};
        hold_reset();
        load_program();
        poke(16'h80, 16'h0005);
        model_run(mcyc);
        run_to_halt(200, cyc);
        n_checks++;
        if (dut.rmem.mem_data[16'h80] !== 16'h0008) begin
            n_fail++; $display("FAIL ldst_mem80: got %h expected 0008", dut.rmem.mem_data[16'h80]);
        end
        n_checks++;
        if (cyc !== 20) begin
            n_fail++; $display("FAIL ldst_cycles: got %0d expected 20", cyc);
        end
        n_checks++;
        if (mcyc !== 20 || m_mem[16'h80] !== 16'h0008) begin
            n_fail++; $display("FAIL ldst_model: got %0d/%h expected 20/0008", mcyc, m_mem[16'h80]);
        end
        $display("test_load_store: mem[80]=%h cycles=%0d", dut.rmem.mem_data[16'h80], cyc);
    endtask

    task automatic build_find_max();
        prog_q = '{
            enc_ri(C_LDHI, 0, 8'h01),   enc_rr(C_LD, 2, 0),        enc_ri(C_LDLI, 1, 7),
            enc_ri(C_ADDI, 0, 1),       enc_rr(C_LD, 3, 0),        enc_rr(C_MV, 4, 3),
            enc_rr(C_XOR, 4, 2),        enc_ri(C_BPL, 4, 3),       enc_ri(C_BMI, 3, 6),
            enc_rr(C_MV, 2, 3),         enc_j(4),                  enc_rr(C_MV, 4, 3),
            enc_rr(C_SUB, 4, 2),        enc_ri(C_BMI, 4, 1),       enc_rr(C_MV, 2, 3),
            enc_ri(C_ADDI, 1, -1),      enc_ri(C_BNEZ, 1, -14),    enc_ri(C_LDHI, 5, 8'h01),
            enc_ri(C_ADDI, 5, 8),       enc_rr(C_ST, 2, 5),        enc_rr(C_HALT, 0, 0)};
    endtask

    task automatic test_find_max();
        logic [15:0] data [8];
        logic [15:0] best;
        int cyc, mcyc;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                data = '{16'd3, 16'hFFFE, 16'd9, 16'h7FFF, 16'd5, 16'h8000, 16'd1, 16'd9};
            end else begin
                for (int i = 0; i < 8; i++) data[i] = 16'($urandom);
            end
            best = data[0];
            for (int i = 1; i < 8; i++) if ($signed(data[i]) > $signed(best)) best = data[i];
            build_find_max();
            hold_reset();
            load_program();
            for (int i = 0; i < 8; i++) poke(16'h100 + i, data[i]);
            model_run(mcyc);
            run_to_halt(3000, cyc);
            n_checks++;
            if (dut.rmem.mem_data[16'h108] !== best) begin
                n_fail++; $display("FAIL find_max[%0d]: got %h expected %h", it, dut.rmem.mem_data[16'h108], best);
            end
            n_checks++;
            if (cyc !== mcyc || ledg[8] !== 1'b1) begin
                n_fail++; $display("FAIL find_max_cycles[%0d]: got %0d expected %0d", it, cyc, mcyc);
            end
            $display("test_find_max[%0d]: max=%h cycles=%0d", it, best, cyc);
        end
    endtask

    task automatic test_branches_wrap();
        int cyc, mcyc;
        prog_q = '{
            enc_ri(C_LDLI, 1, 0),   enc_ri(C_BEZ, 1, 2),    enc_ri(C_LDLI, 7, 8'h55),
            enc_ri(C_LDLI, 7, 8'h55), enc_ri(C_LDLI, 2, 5), enc_ri(C_BEZ, 2, 1),
            enc_ri(C_ADDI, 6, 1),   enc_j(1),               enc_ri(C_LDLI, 7, 8'h66),
            enc_ri(C_LDHI, 3, 8'h04), enc_rr(C_LD, 4, 3),   enc_ri(C_LDHI, 3, 8'h06),
            enc_rr(C_ST, 2, 3),     enc_j(2),               enc_ri(C_ADDI, 5, 1),
            enc_rr(C_HALT, 0, 0),   enc_j(-3)};
        hold_reset();
        load_program();
        model_run(mcyc);
        run_to_halt(400, cyc);
        n_checks++;
        if (dut.regs_q[7] !== 16'h0 || dut.regs_q[6] !== 16'h1) begin
            n_fail++; $display("FAIL bez_paths: got r7=%h r6=%h expected r7=0000 r6=0001", dut.regs_q[7], dut.regs_q[6]);
        end
        n_checks++;
        if (dut.regs_q[4] !== 16'h4900) begin
            n_fail++; $display("FAIL wrap_load: got %h expected 4900", dut.regs_q[4]);
        end
        n_checks++;
        if (dut.rmem.mem_data[16'h200] !== 16'h0005) begin
            n_fail++; $display("FAIL wrap_store: got %h expected 0005", dut.rmem.mem_data[16'h200]);
        end
        n_checks++;
        if (dut.regs_q[5] !== 16'h1 || dut.pc_q !== 16'd16) begin
            n_fail++; $display("FAIL jmp_negative: got r5=%h pc=%h expected r5=0001 pc=0010", dut.regs_q[5], dut.pc_q);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dut.regs_q[i] !== m_r[i]) begin
                n_fail++; $display("FAIL branch_model_r%0d: got %h expected %h", i, dut.regs_q[i], m_r[i]);
            end
        end
        n_checks++;
        if (cyc !== mcyc || dut.pc_q !== m_pc) begin
            n_fail++; $display("FAIL branch_model_pc: got %0d/%h expected %0d/%h", cyc, dut.pc_q, mcyc, m_pc);
        end
        $display("test_branches_wrap: pc=%h cycles=%0d", dut.pc_q, cyc);
    endtask

    task automatic test_reset_mid_store();
        int cyc;
        prog_q = '{enc_ri(C_LDLI, 1, 8'h22), enc_ri(C_LDLI, 2, 8'h40),
                   enc_rr(C_ST, 1, 2), enc_rr(C_HALT, 0, 0)};
        hold_reset();
        load_program();
        poke(16'h40, 16'hBEEF);
        key[0] = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        key[0] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.rmem.mem_data[16'h40] !== 16'hBEEF) begin
            n_fail++; $display("FAIL store_discard: got %h expected beef", dut.rmem.mem_data[16'h40]);
        end
        n_checks++;
        if (ledg[3:0] !== 4'b0001 || dut.pc_q !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_state: got %b pc=%h expected 0001 pc=0000", ledg[3:0], dut.pc_q);
        end
        run_to_halt(100, cyc);
        n_checks++;
        if (dut.rmem.mem_data[16'h40] !== 16'h0022 || cyc !== 13) begin
            n_fail++; $display("FAIL rerun_store: got %h/%0d expected 0022/13", dut.rmem.mem_data[16'h40], cyc);
        end
        $display("test_reset_mid_store: mem[40]=%h cycles=%0d", dut.rmem.mem_data[16'h40], cyc);
    endtask

    task automatic test_run_enable_display();
        int k;
        logic [15:0] exp_pc, exp_r3, exp_ir;
        logic [15:0] addi_w, jmp_w;
        addi_w = enc_ri(C_ADDI, 3, 1);
        jmp_w  = enc_j(-2);
        prog_q = '{addi_w, jmp_w};
        k = $urandom_range(4, 30);
        hold_reset();
        load_program();
        key[0] = 1'b1;
        repeat (3 * k) @(posedge clk);
        #1;
        sw[17] = 1'b0;
        exp_pc = 16'(k % 2);
        exp_r3 = 16'((k + 1) / 2);
        exp_ir = ((k - 1) % 2 == 0) ? addi_w : jmp_w;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({hex7, hex6, hex5, hex4} !== glyphs16(exp_pc) || ledg[3:0] !== 4'b0001) begin
            n_fail++; $display("FAIL hold_pc_state: got %h/%b expected pc %h state 0001",
                {hex7, hex6, hex5, hex4}, ledg[3:0], exp_pc);
        end
        n_checks++;
        if (dut.regs_q[3] !== exp_r3) begin
            n_fail++; $display("FAIL hold_r3: got %h expected %h", dut.regs_q[3], exp_r3);
        end
        sw[16] = 1'b1;
        #1;
        n_checks++;
        if ({hex3, hex2, hex1, hex0} !== glyphs16(exp_ir)) begin
            n_fail++; $display("FAIL disp_ir: got %h expected glyphs of %h", {hex3, hex2, hex1, hex0}, exp_ir);
        end
        sw[16] = 1'b0;
        sw[2:0] = 3'd3;
        #1;
        n_checks++;
        if ({hex3, hex2, hex1, hex0} !== glyphs16(exp_r3)) begin
            n_fail++; $display("FAIL disp_r3: got %h expected glyphs of %h", {hex3, hex2, hex1, hex0}, exp_r3);
        end
        sw[17] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (k % 2 == 0) exp_r3 = exp_r3 + 16'd1;
        exp_pc = 16'((k + 1) % 2);
        n_checks++;
        if ({hex7, hex6, hex5, hex4} !== glyphs16(exp_pc) || {hex3, hex2, hex1, hex0} !== glyphs16(exp_r3)) begin
            n_fail++; $display("FAIL resume: got pc %h r3 %h expected glyphs of %h/%h",
                {hex7, hex6, hex5, hex4}, {hex3, hex2, hex1, hex0}, exp_pc, exp_r3);
        end
        $display("test_run_enable_display: k=%0d pc=%h r3=%h", k, exp_pc, exp_r3);
    endtask

    initial begin
        key = 4'b1110;
        sw  = 18'h20000;
        test_reset();
        test_alu_imm();
        test_random_alu();
        test_load_store();
        test_find_max();
        test_branches_wrap();
        test_reset_mid_store();
        test_run_enable_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
